// File: rtl/sb_rdi_if.sv
// sb_rdi_if: RDI request, adapter lp_cfg and serializer handshakes of the sideband RDI encoder.
interface sb_rdi_if;
  logic        msg_valid;
  logic [3:0]  msg_no;
  logic        msg_ack;
  logic [31:0] lp_cfg;
  logic        lp_cfg_vld;
  logic        lp_cfg_ready;
  logic        lp_nerror;
  logic [63:0] ser_data;
  logic        ser_valid;
  logic        ser_ready;
  modport master (
    input  msg_valid, msg_no, lp_cfg, lp_cfg_vld, ser_ready,
    output msg_ack, lp_cfg_ready, lp_nerror, ser_data, ser_valid
  );
  modport slave (
    output msg_valid, msg_no, lp_cfg, lp_cfg_vld, ser_ready,
    input  msg_ack, lp_cfg_ready, lp_nerror, ser_data, ser_valid
  );
endinterface

// File: rtl/sb_rdi_encoder.sv
// sb_rdi_encoder: encodes RDI FSM messages and adapter lp_cfg phases into 64-bit sideband packets.
module sb_rdi_encoder (
  input logic      i_clk,
  input logic      i_rst_n,
  sb_rdi_if.master bus
);
  typedef enum logic [2:0] {IDLE, RDI_PKT, ADP_COLLECT, ADP_HDR, ADP_DATA, ERROR} state_t;
  state_t      state;
  logic [31:0] w [4];
  logic [1:0]  cnt;
  logic [63:0] rdi_pkt, ser_data;
  logic        armed, msg_ack, lp_nerror, ser_valid, accept_lp, has_data;

  function automatic logic [63:0] encode(input logic [3:0] no);
    logic [7:0]  sub;
    logic [63:0] p;
    case (no)
      4'd1, 4'd8:  sub = 8'h01;
      4'd9:        sub = 8'h02;
      4'd2, 4'd10: sub = 8'h04;
      4'd3, 4'd11: sub = 8'h08;
      4'd4, 4'd12: sub = 8'h09;
      4'd5, 4'd13: sub = 8'h0A;
      4'd6, 4'd14: sub = 8'h0B;
      4'd7, 4'd15: sub = 8'h0C;
      default:     sub = 8'h00;
    endcase
    p = '0;
    p[4:0] = 5'b10010;
    p[21:14] = no[3] ? 8'h02 : 8'h01;
    p[39:32] = sub;
    p[58:56] = 3'b010;
    p[62] = ^{p[63], p[61:0]};
    return p;
  endfunction

  // armed keeps ready low while reset is held and for the first cycle after release
  assign has_data = w[0][4:0] == 5'b11011;
  assign bus.lp_cfg_ready = state == ADP_COLLECT || (state == IDLE && armed && !bus.msg_valid);
  assign accept_lp = bus.lp_cfg_vld && bus.lp_cfg_ready;
  assign bus.msg_ack = msg_ack;
  assign bus.lp_nerror = lp_nerror;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_data = ser_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      w <= '{default: '0};
      cnt <= '0;
      rdi_pkt <= '0;
      armed <= 1'b0;
      msg_ack <= 1'b0;
      lp_nerror <= 1'b0;
      ser_valid <= 1'b0;
      ser_data <= '0;
    end else begin
      armed <= 1'b1;
      msg_ack <= 1'b0;
      lp_nerror <= 1'b0;
      case (state)
        IDLE:
          if (bus.msg_valid && !msg_ack) begin
            rdi_pkt <= encode(bus.msg_no);
            state <= bus.msg_no == 4'd0 ? ERROR : RDI_PKT;
            msg_ack <= bus.msg_no == 4'd0;
            lp_nerror <= bus.msg_no == 4'd0;
          end else if (accept_lp) begin
            w[0] <= bus.lp_cfg;
            cnt <= 2'd1;
            state <= ADP_COLLECT;
          end
        ADP_COLLECT:
          if (accept_lp) begin
            w[cnt] <= bus.lp_cfg;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd1) begin
              state <= w[0][4:0] == 5'b10010 ? ADP_HDR : has_data ? ADP_COLLECT : ERROR;
              lp_nerror <= w[0][4:0] != 5'b10010 && !has_data;
            end else if (cnt == 2'd3) begin
              state <= ADP_HDR;
            end
          end
        // each sending state spends one cycle loading the output register, then waits for ready
        RDI_PKT, ADP_HDR, ADP_DATA:
          if (!ser_valid) begin
            ser_valid <= 1'b1;
            ser_data <= state == RDI_PKT ? rdi_pkt : state == ADP_HDR ? {w[1], w[0]} : {w[3], w[2]};
          end else if (bus.ser_ready) begin
            ser_valid <= 1'b0;
            msg_ack <= state == RDI_PKT;
            state <= state == ADP_HDR && has_data ? ADP_DATA : IDLE;
          end
        ERROR: begin
          state <= IDLE;
          cnt <= '0;
          w <= '{default: '0};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_rdi_encoder.sv
// tb_sb_rdi_encoder: directed stimulus checked against an expected-packet queue built from the message map.
module tb_sb_rdi_encoder;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int n_ack = 0;
  int n_nerr = 0;
  int n_valid = 0;
  logic [63:0] exp_q [$];
  logic [7:0] sub_tab [16] = '{8'h00, 8'h01, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C,
                               8'h01, 8'h02, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
  logic prev_hold = 1'b0;
  logic prev_hs = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_nerr = 1'b0;
  logic [63:0] prev_data = '0;

  sb_rdi_if bus();
  sb_rdi_encoder dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // packet from the message map with plain arithmetic; cp is the parity of every other bit
  function automatic logic [63:0] model(input int no);
    logic [63:0] p;
    p = 64'h12 | ((no < 8 ? 64'd1 : 64'd2) << 14) | ({56'd0, sub_tab[no]} << 32) | (64'd2 << 56);
    p[62] = ^p;
    return p;
  endfunction

  always @(negedge i_clk) begin
    #2;
    if (!i_rst_n) begin
      prev_hold = 1'b0;
      prev_hs = 1'b0;
      prev_ack = 1'b0;
      prev_nerr = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.ser_valid, 1);
        chk("hold_data", bus.ser_data, prev_data);
      end
      if (prev_hs) chk("gap_after_handshake", bus.ser_valid, 0);
      if (prev_ack) chk("ack_width", bus.msg_ack, 0);
      if (prev_nerr) chk("nerror_width", bus.lp_nerror, 0);
      if (bus.ser_valid) begin
        n_valid++;
        chk("ready_while_sending", bus.lp_cfg_ready, 0);
        if (bus.ser_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_packet: got %h expected none", bus.ser_data);
          end else begin
            chk("packet", bus.ser_data, exp_q.pop_front());
          end
        end
      end
      if (bus.msg_ack) n_ack++;
      if (bus.lp_nerror) n_nerr++;
      prev_hold = bus.ser_valid && !bus.ser_ready;
      prev_hs = bus.ser_valid && bus.ser_ready;
      prev_ack = bus.msg_ack;
      prev_nerr = bus.lp_nerror;
      prev_data = bus.ser_data;
    end
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ser_valid"}, bus.ser_valid, 0);
    chk({tag, "_ser_data"}, bus.ser_data, 0);
    chk({tag, "_msg_ack"}, bus.msg_ack, 0);
    chk({tag, "_lp_nerror"}, bus.lp_nerror, 0);
    chk({tag, "_lp_cfg_ready"}, bus.lp_cfg_ready, 0);
  endtask

  task automatic send_word(input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    bus.lp_cfg = d;
    bus.lp_cfg_vld = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      ok = bus.lp_cfg_ready;
      if (!ok) @(negedge i_clk);
    end
    chk("word_accept", ok, 1);
    step();
    bus.lp_cfg_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic rdi_req(input logic [3:0] no);
    exp_q.push_back(model(no));
    bus.msg_no = no;
    bus.msg_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.msg_ack; i++) step();
    chk("rdi_ack_wait", bus.msg_ack, 1);
    bus.msg_valid = 1'b0;
    step();
  endtask

  task automatic rdi_lit(input logic [3:0] no, input logic [63:0] lit);
    int a0, v0;
    a0 = n_ack;
    v0 = n_valid;
    exp_q.push_back(model(no));
    bus.msg_no = no;
    bus.msg_valid = 1'b1;
    step();
    chk("rdi_valid_n", bus.ser_valid, 0);
    step();
    chk("rdi_valid_n1", bus.ser_valid, 1);
    chk("rdi_data", bus.ser_data, lit);
    step();
    chk("rdi_ack", bus.msg_ack, 1);
    chk("rdi_valid_n2", bus.ser_valid, 0);
    bus.msg_valid = 1'b0;
    step();
    step();
    chk("rdi_ack_pulses", n_ack - a0, 1);
    chk("rdi_valid_cycles", n_valid - v0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, e0;
    bus.msg_valid = 1'b0;
    bus.msg_no = 4'd0;
    bus.lp_cfg = '0;
    bus.lp_cfg_vld = 1'b0;
    bus.ser_ready = 1'b0;
    step();
    step();
    chk_zero("reset");
    i_rst_n = 1'b1;
    step();
    step();
    bus.ser_ready = 1'b1;
    rdi_lit(4'd4, 64'h0200_0009_0000_4012);
    rdi_lit(4'd1, 64'h4200_0001_0000_4012);
    for (int n = 1; n < 16; n++) rdi_req(4'(n));
    drain("rdi_sweep_drain");

    // msg 15 with the serializer stalled for five valid cycles
    bus.ser_ready = 1'b0;
    exp_q.push_back(model(15));
    bus.msg_no = 4'd15;
    bus.msg_valid = 1'b1;
    step();
    step();
    chk("stall_data", bus.ser_data, 64'h0200_000C_0000_8012);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_no_ack", bus.msg_ack, 0);
      chk("stall_valid", bus.ser_valid, 1);
    end
    bus.ser_ready = 1'b1;
    step();
    chk("stall_ack", bus.msg_ack, 1);
    bus.msg_valid = 1'b0;
    step();

    // adapter packet without data
    exp_q.push_back({32'h0100_0000, 32'h0000_0012});
    send_word(32'h0000_0012);
    send_word(32'h0100_0000);
    chk("adp_ready_low", bus.lp_cfg_ready, 0);
    step();
    chk("adp_valid", bus.ser_valid, 1);
    chk("adp_data", bus.ser_data, 64'h0100_0000_0000_0012);
    step();
    chk("adp_idle_ready", bus.lp_cfg_ready, 1);
    chk("adp_drained", exp_q.size(), 0);

    // adapter packet with data, collection gap and toggling ready
    bus.ser_ready = 1'b0;
    exp_q.push_back({32'h1111_2222, 32'h0000_001B});
    exp_q.push_back({32'h5555_6666, 32'h3333_4444});
    send_word(32'h0000_001B);
    send_word(32'h1111_2222);
    step();
    step();
    send_word(32'h3333_4444);
    send_word(32'h5555_6666);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      bus.ser_ready = i[0];
      step();
    end
    chk("burst_drain", exp_q.size(), 0);
    bus.ser_ready = 1'b1;
    step();
    step();

    // simultaneous requests: RDI first, adapter word0 held off until IDLE returns
    exp_q.push_back(model(3));
    exp_q.push_back({32'h0, 32'h0000_0012});
    bus.msg_no = 4'd3;
    bus.msg_valid = 1'b1;
    bus.lp_cfg = 32'h0000_0012;
    bus.lp_cfg_vld = 1'b1;
    #1;
    chk("prio_ready", bus.lp_cfg_ready, 0);
    for (int i = 0; i < 20 && !bus.msg_ack; i++) begin
      step();
      chk("prio_hold_ready", bus.lp_cfg_ready, 0);
    end
    chk("prio_ack", bus.msg_ack, 1);
    bus.msg_valid = 1'b0;
    send_word(32'h0000_0012);
    send_word(32'h0000_0000);
    drain("prio_drain");
    step();

    // illegal msg_no: ack plus nerror, no packet
    a0 = n_ack;
    e0 = n_nerr;
    bus.msg_no = 4'd0;
    bus.msg_valid = 1'b1;
    step();
    chk("illegal_ack", bus.msg_ack, 1);
    chk("illegal_nerror", bus.lp_nerror, 1);
    bus.msg_valid = 1'b0;
    step();
    chk("illegal_ack_drop", bus.msg_ack, 0);
    chk("illegal_nerror_drop", bus.lp_nerror, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("illegal_no_packet", bus.ser_valid, 0);
    end
    chk("illegal_ack_count", n_ack - a0, 1);
    chk("illegal_nerr_count", n_nerr - e0, 1);

    // illegal adapter opcode: nerror only
    a0 = n_ack;
    send_word(32'h0000_0001);
    send_word(32'h0000_0000);
    chk("bad_op_nerror", bus.lp_nerror, 1);
    chk("bad_op_ready", bus.lp_cfg_ready, 0);
    step();
    chk("bad_op_nerror_drop", bus.lp_nerror, 0);
    chk("bad_op_ready_back", bus.lp_cfg_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bad_op_no_packet", bus.ser_valid, 0);
    end
    chk("bad_op_no_ack", n_ack - a0, 0);

    // reset after the w2 capture
    send_word(32'h0000_001B);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    i_rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    step();
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_quiet", bus.ser_valid, 0);
    end
    rdi_lit(4'd6, 64'h4200_000B_0000_4012);
    for (int i = 0; i < 4; i++) step();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
